arp_table_search: RTL and testbench

Performs the next-hop IP to ARP-table index search for the router output port lookup pipeline. Accepts one next-hop IP and output-queue value per request, scans a 32-entry ARP IP table one entry per cycle, and returns `arp_lookup`/`index_hit`/`oq_reg`. These are held stable for the downstream stage that selects the destination MAC from the matching `dest_mac_table` entry. Hit and miss counts are kept for software readback.

---
 rtl/arp_table_search.sv | 155 +++++++++++++++
 tb/tb_arp_table_search.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_table_search.sv
// arp_table_search: sequential next-hop IP to ARP index lookup.
// Scans the ARP IP column one entry per cycle, first valid match wins.
//
// Ports:
//   AXI_ACLK, AXI_RESETN      clock, async active-low reset
//   req_valid/req_ready       request handshake (ready only when IDLE)
//   req_ip, req_oq            next-hop IP to find, queue value to pass through
//   arp_ip_table              flattened IP column, entry i at [i*IP_WIDTH +: IP_WIDTH]
//   arp_entry_valid           per-entry valid bits
//   rsp_valid                 one-cycle pulse when a new result is held
//   arp_lookup, index_hit     held hit flag and matching index (0 on miss)
//   oq_reg                    held queue value of the last completed search
//   counter_clear             synchronous clear of both counters
//   arp_hit_count/miss_count  completed-search statistics, wrap mod 2^32
module arp_table_search #(
    parameter int TABLE_DEPTH = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int IP_WIDTH    = 32
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_RESETN,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [IP_WIDTH-1:0]             req_ip,
    input  logic [31:0]                     req_oq,
    input  logic [TABLE_DEPTH*IP_WIDTH-1:0] arp_ip_table,
    input  logic [TABLE_DEPTH-1:0]          arp_entry_valid,
    output logic                            rsp_valid,
    output logic                            arp_lookup,
    output logic [INDEX_WIDTH-1:0]          index_hit,
    output logic [31:0]                     oq_reg,
    input  logic                            counter_clear,
    output logic [31:0]                     arp_hit_count,
    output logic [31:0]                     arp_miss_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic [IP_WIDTH-1:0]    ip_q, ip_d;
    logic [31:0]            oq_q, oq_d;
    logic                   lookup_q, lookup_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]            oqr_q, oqr_d;
    logic [31:0]            hit_cnt_q, hit_cnt_d;
    logic [31:0]            miss_cnt_q, miss_cnt_d;
    logic                   rsp_q, rsp_d;
    logic                   rdy_q, rdy_d;

    logic [IP_WIDTH-1:0]    entry_ip;
    logic                   match;
    logic                   last;

    // Entry under the pointer is read live, so table writes during a
    // scan are seen only for entries not yet examined.
    assign entry_ip = arp_ip_table[int'(ptr_q) * IP_WIDTH +: IP_WIDTH];
    assign match    = arp_entry_valid[ptr_q] & (entry_ip == ip_q);
    assign last     = (ptr_q == INDEX_WIDTH'(TABLE_DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ip_d       = ip_q;
        oq_d       = oq_q;
        lookup_d   = lookup_q;
        idx_d      = idx_q;
        oqr_d      = oqr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ip_d    = req_ip;
                    oq_d    = req_oq;
                    ptr_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (match) begin
                    lookup_d = 1'b1;
                    idx_d    = ptr_q;
                    oqr_d    = oq_q;
                    state_d  = DONE;
                end else if (last) begin
                    lookup_d = 1'b0;
                    idx_d    = '0;
                    oqr_d    = oq_q;
                    state_d  = DONE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (lookup_q) hit_cnt_d = hit_cnt_q + 32'd1;
                else          miss_cnt_d = miss_cnt_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over a same-cycle increment.
        if (counter_clear) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end
    end

    // Handshake/pulse flags are registered copies of the next state.
    assign rsp_d = (state_d == DONE);
    assign rdy_d = (state_d == IDLE);

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            ip_q       <= '0;
            oq_q       <= '0;
            lookup_q   <= 1'b0;
            idx_q      <= '0;
            oqr_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            rsp_q      <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ip_q       <= ip_d;
            oq_q       <= oq_d;
            lookup_q   <= lookup_d;
            idx_q      <= idx_d;
            oqr_q      <= oqr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            rsp_q      <= rsp_d;
            rdy_q      <= rdy_d;
        end
    end

    assign req_ready      = rdy_q;
    assign rsp_valid      = rsp_q;
    assign arp_lookup     = lookup_q;
    assign index_hit      = idx_q;
    assign oq_reg         = oqr_q;
    assign arp_hit_count  = hit_cnt_q;
    assign arp_miss_count = miss_cnt_q;

endmodule

// File: tb/tb_arp_table_search.sv
// tb_arp_table_search: scoreboard bench for arp_table_search.
// Expected results come from a first-valid-match model of the table.
module tb_arp_table_search;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_ip;
    logic [31:0] req_oq;
    logic [1023:0] arp_ip_table;
    logic [31:0] arp_entry_valid;
    logic        rsp_valid;
    logic        arp_lookup;
    logic [4:0]  index_hit;
    logic [31:0] oq_reg;
    logic        counter_clear;
    logic [31:0] arp_hit_count;
    logic [31:0] arp_miss_count;

    logic [31:0] tbl [32];

    typedef struct {
        logic        hit;
        logic [4:0]  idx;
        logic [31:0] oq;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int nvec = 0;
    int nerr = 0;
    logic [31:0] exp_hits = 0;
    logic [31:0] exp_miss = 0;

    arp_table_search dut (
        .AXI_ACLK        (clk),
        .AXI_RESETN      (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_ip          (req_ip),
        .req_oq          (req_oq),
        .arp_ip_table    (arp_ip_table),
        .arp_entry_valid (arp_entry_valid),
        .rsp_valid       (rsp_valid),
        .arp_lookup      (arp_lookup),
        .index_hit       (index_hit),
        .oq_reg          (oq_reg),
        .counter_clear   (counter_clear),
        .arp_hit_count   (arp_hit_count),
        .arp_miss_count  (arp_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        arp_ip_table = '0;
        for (int i = 0; i < 32; i++)
            arp_ip_table[i*32 +: 32] = tbl[i];
    end

    function automatic exp_t model(input logic [31:0] ip,
                                   input logic [31:0] oq);
        exp_t e;
        e.hit = 1'b0;
        e.idx = '0;
        e.oq  = oq;
        e.lat = 33;
        for (int i = 0; i < 32; i++) begin
            if (arp_entry_valid[i] && tbl[i] == ip) begin
                e.hit = 1'b1;
                e.idx = 5'(i);
                e.lat = i + 2;
                return e;
            end
        end
        return e;
    endfunction

    task automatic clear_table();
        for (int i = 0; i < 32; i++)
            tbl[i] = 32'h7700_0000 + 32'(i);
        arp_entry_valid = '0;
    endtask

    // Drives one request from an idle negedge and waits for rsp_valid.
    // Ends on the idle negedge after the pulse, counters already updated.
    task automatic send(input logic [31:0] ip, input logic [31:0] oq,
                        input bit clr, output int lat,
                        output bit tmo, output bit chg);
        logic        l0;
        logic [4:0]  i0;
        logic [31:0] o0;
        l0 = arp_lookup;
        i0 = index_hit;
        o0 = oq_reg;
        lat = 0;
        tmo = 1'b1;
        chg = 1'b0;
        req_valid = 1'b1;
        req_ip = ip;
        req_oq = oq;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (rsp_valid) begin
                lat = n;
                tmo = 1'b0;
                if (clr) counter_clear = 1'b1;
                break;
            end
            if (arp_lookup !== l0 || index_hit !== i0 || oq_reg !== o0)
                chg = 1'b1;
        end
        @(negedge clk);
        counter_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1;
        req_ip = 32'h0;
        req_oq = 32'h0;
        counter_clear = 1'b0;
        clear_table();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nvec++;
            if ({req_ready, rsp_valid, arp_lookup, index_hit} !== 8'b1000_0000) begin
                nerr++;
                $display("FAIL reset_flags: got rdy=%b rsp=%b lk=%b idx=%0d want 1 0 0 0",
                         req_ready, rsp_valid, arp_lookup, index_hit);
            end
            nvec++;
            if ({oq_reg, arp_hit_count, arp_miss_count} !== 96'h0) begin
                nerr++;
                $display("FAIL reset_regs: got oq=%h hit=%h miss=%h want 0",
                         oq_reg, arp_hit_count, arp_miss_count);
            end
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hit5();
        int lat;
        bit tmo, chg;
        exp_t e;
        clear_table();
        tbl[5] = 32'h0A00_0102;
        arp_entry_valid[5] = 1'b1;
        sb.push_back(model(32'h0A00_0102, 32'h4));
        send(32'h0A00_0102, 32'h4, 1'b0, lat, tmo, chg);
        e = sb.pop_front();
        exp_hits++;
        nvec++;
        if (tmo || {arp_lookup, index_hit, oq_reg, lat} !==
                   {e.hit, e.idx, e.oq, e.lat} || e.lat != 7) begin
            nerr++;
            $display("FAIL hit5: got lk=%b idx=%0d oq=%h lat=%0d want 1 5 4 7",
                     arp_lookup, index_hit, oq_reg, lat);
        end
        nvec++;
        if (chg || req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL hit5_held: got chg=%b rdy=%b want 0 1", chg, req_ready);
        end
        nvec++;
        if (arp_hit_count !== exp_hits || arp_miss_count !== exp_miss) begin
            nerr++;
            $display("FAIL hit5_cnt: got %0d/%0d want %0d/%0d",
                     arp_hit_count, arp_miss_count, exp_hits, exp_miss);
        end
    endtask

    task automatic test_dup_invalid();
        int lat;
        bit tmo, chg;
        exp_t e;
        clear_table();
        tbl[3] = 32'hC0A8_0001;
        tbl[9] = 32'hC0A8_0001;
        arp_entry_valid[9] = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) arp_entry_valid[3] = 1'b1;
            sb.push_back(model(32'hC0A8_0001, 32'h10 + 32'(pass)));
            send(32'hC0A8_0001, 32'h10 + 32'(pass), 1'b0, lat, tmo, chg);
            e = sb.pop_front();
            exp_hits++;
            nvec++;
            if (tmo || {arp_lookup, index_hit, oq_reg, lat} !==
                       {e.hit, e.idx, e.oq, e.lat} ||
                index_hit !== (pass == 0 ? 5'd9 : 5'd3)) begin
                nerr++;
                $display("FAIL dup_%0d: got lk=%b idx=%0d oq=%h lat=%0d want %b %0d %h %0d",
                         pass, arp_lookup, index_hit, oq_reg, lat,
                         e.hit, e.idx, e.oq, e.lat);
            end
        end
        nvec++;
        if (arp_hit_count !== exp_hits) begin
            nerr++;
            $display("FAIL dup_cnt: got %0d want %0d", arp_hit_count, exp_hits);
        end
    endtask

    task automatic test_miss();
        int lat;
        bit tmo, chg;
        exp_t e;
        clear_table();
        arp_entry_valid = '1;
        tbl[0] = 32'h0;
        sb.push_back(model(32'h0102_0304, 32'hABCD));
        send(32'h0102_0304, 32'hABCD, 1'b0, lat, tmo, chg);
        e = sb.pop_front();
        exp_miss++;
        nvec++;
        if (tmo || {arp_lookup, index_hit, oq_reg, lat} !==
                   {e.hit, e.idx, e.oq, e.lat} || lat != 33) begin
            nerr++;
            $display("FAIL miss: got lk=%b idx=%0d oq=%h lat=%0d want 0 0 abcd 33",
                     arp_lookup, index_hit, oq_reg, lat);
        end
        nvec++;
        if (chg || arp_miss_count !== exp_miss || arp_hit_count !== exp_hits) begin
            nerr++;
            $display("FAIL miss_cnt: got chg=%b %0d/%0d want 0 %0d/%0d", chg,
                     arp_hit_count, arp_miss_count, exp_hits, exp_miss);
        end
        // IP 0.0.0.0 at entry 0 is a normal match.
        sb.push_back(model(32'h0, 32'h5));
        send(32'h0, 32'h5, 1'b0, lat, tmo, chg);
        e = sb.pop_front();
        exp_hits++;
        nvec++;
        if (tmo || {arp_lookup, index_hit, oq_reg, lat} !==
                   {e.hit, e.idx, e.oq, e.lat} || lat != 2) begin
            nerr++;
            $display("FAIL zero_ip: got lk=%b idx=%0d oq=%h lat=%0d want 1 0 5 2",
                     arp_lookup, index_hit, oq_reg, lat);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        bit tmo, chg;
        bit seen;
        exp_t e;
        clear_table();
        seen = 1'b0;
        req_valid = 1'b1;
        req_ip = 32'h0102_0304;
        req_oq = 32'h99;
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        rst_n = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        nvec++;
        if (seen || req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rst_mid: got rsp_seen=%b rdy=%b want 0 1", seen, req_ready);
        end
        nvec++;
        if (arp_hit_count !== 32'h0 || arp_miss_count !== 32'h0 || arp_lookup !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_regs: got %0d/%0d lk=%b want 0/0 0",
                     arp_hit_count, arp_miss_count, arp_lookup);
        end
        tbl[12] = 32'h0102_0304;
        arp_entry_valid[12] = 1'b1;
        sb.push_back(model(32'h0102_0304, 32'h77));
        send(32'h0102_0304, 32'h77, 1'b0, lat, tmo, chg);
        e = sb.pop_front();
        exp_hits++;
        nvec++;
        if (tmo || {arp_lookup, index_hit, oq_reg, lat} !==
                   {e.hit, e.idx, e.oq, e.lat} || arp_hit_count !== exp_hits) begin
            nerr++;
            $display("FAIL rst_mid_next: got lk=%b idx=%0d oq=%h lat=%0d hit=%0d want 1 12 77 14 %0d",
                     arp_lookup, index_hit, oq_reg, lat, arp_hit_count, exp_hits);
        end
    endtask

    task automatic test_counter_clear();
        int lat;
        bit tmo, chg;
        exp_t e;
        clear_table();
        tbl[1] = 32'h0B0B_0B0B;
        arp_entry_valid[1] = 1'b1;
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        @(negedge clk);
        exp_hits = 32'hFFFF_FFFF;
        nvec++;
        if (arp_hit_count !== exp_hits) begin
            nerr++;
            $display("FAIL preload: got %h want ffffffff", arp_hit_count);
        end
        sb.push_back(model(32'h0B0B_0B0B, 32'h1));
        send(32'h0B0B_0B0B, 32'h1, 1'b0, lat, tmo, chg);
        e = sb.pop_front();
        exp_hits++;
        nvec++;
        if (tmo || arp_hit_count !== exp_hits || exp_hits !== 32'h0 ||
            index_hit !== e.idx) begin
            nerr++;
            $display("FAIL wrap: got hit=%h idx=%0d want 0 %0d",
                     arp_hit_count, index_hit, e.idx);
        end
        send(32'h0B0B_0B0B, 32'h2, 1'b0, lat, tmo, chg);
        send(32'h0404_0404, 32'h3, 1'b0, lat, tmo, chg);
        nvec++;
        if (arp_hit_count !== 32'd1 || arp_miss_count !== exp_miss + 32'd1) begin
            nerr++;
            $display("FAIL pre_clear: got %0d/%0d want 1/%0d",
                     arp_hit_count, arp_miss_count, exp_miss + 32'd1);
        end
        send(32'h0B0B_0B0B, 32'h4, 1'b1, lat, tmo, chg);
        exp_hits = 0;
        exp_miss = 0;
        nvec++;
        if (tmo || arp_hit_count !== 32'h0 || arp_miss_count !== 32'h0) begin
            nerr++;
            $display("FAIL clear_done: got %0d/%0d want 0/0",
                     arp_hit_count, arp_miss_count);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit tmo, chg;
        exp_t e;
        logic [31:0] ip;
        clear_table();
        for (int i = 0; i < 32; i++) begin
            tbl[i] = $urandom();
            arp_entry_valid[i] = ($urandom_range(0, 3) != 0);
        end
        for (int t = 0; t < 6; t++) begin
            if (t == 5) ip = 32'hFFFF_FFF0;
            else ip = tbl[$urandom_range(0, 31)];
            sb.push_back(model(ip, 32'(t) + 32'h100));
            send(ip, 32'(t) + 32'h100, 1'b0, lat, tmo, chg);
            e = sb.pop_front();
            if (e.hit) exp_hits++;
            else exp_miss++;
            nvec++;
            if (tmo || chg || {arp_lookup, index_hit, oq_reg, lat} !==
                              {e.hit, e.idx, e.oq, e.lat}) begin
                nerr++;
                $display("FAIL b2b_%0d: got lk=%b idx=%0d oq=%h lat=%0d chg=%b want %b %0d %h %0d",
                         t, arp_lookup, index_hit, oq_reg, lat, chg,
                         e.hit, e.idx, e.oq, e.lat);
            end
        end
        nvec++;
        if (arp_hit_count !== exp_hits || arp_miss_count !== exp_miss) begin
            nerr++;
            $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d",
                     arp_hit_count, arp_miss_count, exp_hits, exp_miss);
        end
    endtask

    initial begin
        test_reset();
        test_hit5();
        test_dup_invalid();
        test_miss();
        test_reset_mid_scan();
        test_counter_clear();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
